// File: rtl/r5p_mouse_trace_capture.sv
// Execution-trace capture for the R5P-mouse core: snoops the TCB bus per FSM phase,
// builds one retire record per instruction and streams records out through a FIFO.
module r5p_mouse_trace_capture #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNW     = 32,
  parameter bit          FILT_X0 = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_pha,
  input  logic            i_tcb_vld,
  input  logic            i_tcb_rdy,
  input  logic [XLEN-1:0] i_tcb_adr,
  input  logic [1:0]      i_tcb_siz,
  input  logic [XLEN-1:0] i_tcb_wdt,
  input  logic [XLEN-1:0] i_tcb_rdt,
  input  logic            i_flush,
  output logic            o_trc_vld,
  input  logic            i_trc_rdy,
  output logic [XLEN-1:0] o_trc_pc,
  output logic [31:0]     o_trc_ins,
  output logic            o_trc_rdv,
  output logic [4:0]      o_trc_rd,
  output logic [XLEN-1:0] o_trc_rdw,
  output logic [1:0]      o_trc_mem,
  output logic [1:0]      o_trc_msiz,
  output logic [XLEN-1:0] o_trc_madr,
  output logic [XLEN-1:0] o_trc_mdat,
  output logic [CNW-1:0]  o_cnt_ret,
  output logic [CNW-1:0]  o_cnt_drp,
  output logic            o_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] PHA_IF  = 3'b000;
  localparam logic [2:0] PHA_MLD = 3'b001;
  localparam logic [2:0] PHA_MST = 3'b010;
  localparam logic [2:0] PHA_WB  = 3'b100;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic            rdv;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdw;
    logic [1:0]      mem;
    logic [1:0]      msiz;
    logic [XLEN-1:0] madr;
    logic [XLEN-1:0] mdat;
  } rec_t;

  function automatic logic [XLEN-1:0] f_mask(input logic [1:0] siz, input logic [XLEN-1:0] dat);
    logic [XLEN-1:0] m;
    case (siz)
      2'd0:    m = {{(XLEN-8){1'b0}}, dat[7:0]};
      2'd1:    m = {{(XLEN-16){1'b0}}, dat[15:0]};
      default: m = dat;
    endcase
    return m;
  endfunction

  logic            w_trn, w_if, w_wb, w_mld, w_mst, w_commit;
  logic            r_open, r_pend_ins, r_pend_ld;
  rec_t            r_rec, w_new_rec, w_crec, w_head_nxt, r_head;
  rec_t            r_mem [DEPTH];
  logic [AW:0]     r_wp, r_rp, w_wp_nxt, w_rp_nxt;
  logic            w_full, w_pop, w_push, w_drop, r_trc_vld;
  logic [CNW-1:0]  r_cnt_ret, r_cnt_drp;
  logic            r_ovf;

  assign w_trn    = i_tcb_vld & i_tcb_rdy;
  assign w_if     = w_trn & (i_pha == PHA_IF);
  assign w_wb     = w_trn & (i_pha == PHA_WB);
  assign w_mld    = w_trn & (i_pha == PHA_MLD);
  assign w_mst    = w_trn & (i_pha == PHA_MST);
  assign w_commit = r_open & (w_if | i_flush);

  // Fresh record template and the committed view with late read data bypassed in.
  always_comb begin
    w_new_rec      = '0;
    w_new_rec.pc   = i_tcb_adr;
    w_crec         = r_rec;
    w_crec.ins     = r_pend_ins ? i_tcb_rdt[31:0] : r_rec.ins;
    w_crec.mdat    = r_pend_ld  ? i_tcb_rdt       : r_rec.mdat;
  end

  // Open record: transfer writes come after the pending-data writes so they take priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_open     <= 1'b0;
      r_pend_ins <= 1'b0;
      r_pend_ld  <= 1'b0;
      r_rec      <= '0;
    end else begin
      r_pend_ins <= w_if;
      r_pend_ld  <= w_mld;
      if (r_pend_ins) r_rec.ins  <= i_tcb_rdt[31:0];
      if (r_pend_ld)  r_rec.mdat <= i_tcb_rdt;
      if (w_if) begin
        r_open <= 1'b1;
        r_rec  <= w_new_rec;
      end else if (i_flush) begin
        r_open <= 1'b0;
      end
      if (w_wb) begin
        r_rec.rd  <= i_tcb_adr[6:2];
        r_rec.rdw <= i_tcb_wdt;
        r_rec.rdv <= !(FILT_X0 && (i_tcb_adr[6:2] == 5'd0));
      end
      if (w_mld | w_mst) begin
        r_rec.mem  <= w_mld ? 2'b01 : 2'b10;
        r_rec.madr <= i_tcb_adr;
        r_rec.msiz <= i_tcb_siz;
      end
      if (w_mst) r_rec.mdat <= f_mask(i_tcb_siz, i_tcb_wdt);
    end
  end

  assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop    = r_trc_vld & i_trc_rdy;
  assign w_push   = w_commit & (~w_full | w_pop);
  assign w_drop   = w_commit & w_full & ~w_pop;
  assign w_wp_nxt = r_wp + (AW+1)'(w_push);
  assign w_rp_nxt = r_rp + (AW+1)'(w_pop);

  // Next head: a record written this edge into the slot that becomes head must be forwarded.
  always_comb begin
    w_head_nxt = '0;
    if (w_wp_nxt == w_rp_nxt) begin
      w_head_nxt = '0;
    end else if (w_push && (w_rp_nxt == r_wp)) begin
      w_head_nxt = w_crec;
    end else begin
      w_head_nxt = r_mem[w_rp_nxt[AW-1:0]];
    end
  end

  // FIFO storage, pointers and the registered head stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_trc_vld <= 1'b0;
      r_head    <= '0;
    end else begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= w_crec;
      r_wp      <= w_wp_nxt;
      r_rp      <= w_rp_nxt;
      r_trc_vld <= (w_wp_nxt != w_rp_nxt);
      r_head    <= w_head_nxt;
    end
  end

  // Retire counter wraps; drop counter saturates; overflow flag is sticky.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_ret <= '0;
      r_cnt_drp <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_commit) r_cnt_ret <= r_cnt_ret + CNW'(1'b1);
      if (w_drop && (r_cnt_drp != {CNW{1'b1}})) r_cnt_drp <= r_cnt_drp + CNW'(1'b1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign o_trc_vld  = r_trc_vld;
  assign o_trc_pc   = r_head.pc;
  assign o_trc_ins  = r_head.ins;
  assign o_trc_rdv  = r_head.rdv;
  assign o_trc_rd   = r_head.rd;
  assign o_trc_rdw  = r_head.rdw;
  assign o_trc_mem  = r_head.mem;
  assign o_trc_msiz = r_head.msiz;
  assign o_trc_madr = r_head.madr;
  assign o_trc_mdat = r_head.mdat;
  assign o_cnt_ret  = r_cnt_ret;
  assign o_cnt_drp  = r_cnt_drp;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_r5p_mouse_trace_capture.sv
// Directed bench for r5p_mouse_trace_capture: a bus-level model pushes expected
// records into a scoreboard queue that a monitor pops as the DUT emits them.
module tb_r5p_mouse_trace_capture;
  localparam int DEPTH = 4;
  localparam logic [2:0] IF = 3'b000, MLD = 3'b001, MST = 3'b010, EXE = 3'b011, WB = 3'b100, RS1 = 3'b101;

  typedef struct packed {
    logic [31:0] pc; logic [31:0] ins; logic rdv; logic [4:0] rd; logic [31:0] rdw;
    logic [1:0] mem; logic [1:0] msiz; logic [31:0] madr; logic [31:0] mdat;
  } rec_t;
  typedef struct { rec_t r; bit x0; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] i_pha = EXE;
  logic i_tcb_vld = 1'b0, i_tcb_rdy = 1'b1, i_flush = 1'b0, i_trc_rdy = 1'b1;
  logic [1:0] i_tcb_siz = 2'd0;
  logic [31:0] i_tcb_adr = '0, i_tcb_wdt = '0, i_tcb_rdt = '0;
  logic o_trc_vld, o_trc_rdv, o_ovf, d0_vld, d0_rdv, d0_ovf;
  logic [31:0] o_trc_pc, o_trc_rdw, o_trc_madr, o_trc_mdat, o_cnt_ret, o_cnt_drp;
  logic [31:0] d0_pc, d0_rdw, d0_madr, d0_mdat, d0_ret, d0_drp, o_trc_ins, d0_ins;
  logic [4:0] o_trc_rd, d0_rd;
  logic [1:0] o_trc_mem, o_trc_msiz, d0_mem, d0_msiz;

  int checks = 0, failures = 0;
  exp_t q[$];
  rec_t m_rec;
  bit m_open = 1'b0, m_x0 = 1'b0, m_ovf = 1'b0, g_rdy = 1'b1;
  int m_ret = 0, m_drp = 0;
  logic [31:0] g_rdt = '0;

  always #5 clk = ~clk;

  r5p_mouse_trace_capture #(.XLEN(32), .DEPTH(DEPTH), .CNW(32), .FILT_X0(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_pha(i_pha), .i_tcb_vld(i_tcb_vld), .i_tcb_rdy(i_tcb_rdy),
    .i_tcb_adr(i_tcb_adr), .i_tcb_siz(i_tcb_siz), .i_tcb_wdt(i_tcb_wdt), .i_tcb_rdt(i_tcb_rdt),
    .i_flush(i_flush), .o_trc_vld(o_trc_vld), .i_trc_rdy(i_trc_rdy), .o_trc_pc(o_trc_pc),
    .o_trc_ins(o_trc_ins), .o_trc_rdv(o_trc_rdv), .o_trc_rd(o_trc_rd), .o_trc_rdw(o_trc_rdw),
    .o_trc_mem(o_trc_mem), .o_trc_msiz(o_trc_msiz), .o_trc_madr(o_trc_madr), .o_trc_mdat(o_trc_mdat),
    .o_cnt_ret(o_cnt_ret), .o_cnt_drp(o_cnt_drp), .o_ovf(o_ovf));

  r5p_mouse_trace_capture #(.XLEN(32), .DEPTH(DEPTH), .CNW(32), .FILT_X0(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_pha(i_pha), .i_tcb_vld(i_tcb_vld), .i_tcb_rdy(i_tcb_rdy),
    .i_tcb_adr(i_tcb_adr), .i_tcb_siz(i_tcb_siz), .i_tcb_wdt(i_tcb_wdt), .i_tcb_rdt(i_tcb_rdt),
    .i_flush(i_flush), .o_trc_vld(d0_vld), .i_trc_rdy(i_trc_rdy), .o_trc_pc(d0_pc),
    .o_trc_ins(d0_ins), .o_trc_rdv(d0_rdv), .o_trc_rd(d0_rd), .o_trc_rdw(d0_rdw),
    .o_trc_mem(d0_mem), .o_trc_msiz(d0_msiz), .o_trc_madr(d0_madr), .o_trc_mdat(d0_mdat),
    .o_cnt_ret(d0_ret), .o_cnt_drp(d0_drp), .o_ovf(d0_ovf));

  // Fields that carry no meaning (rd/rdw without a write, memory fields without an access) are ignored.
  function automatic rec_t canon(input rec_t r);
    rec_t c = r;
    if (!c.rdv) begin c.rd = 5'd0; c.rdw = 32'd0; end
    if (c.mem == 2'b00) begin c.msiz = 2'd0; c.madr = 32'd0; c.mdat = 32'd0; end
    return c;
  endfunction

  // Scoreboard monitor: compares the head at every accepted handshake.
  always @(negedge clk) begin : mon
    rec_t obs;
    exp_t e;
    if (!rst && o_trc_vld && i_trc_rdy) begin
      obs.pc = o_trc_pc; obs.ins = o_trc_ins; obs.rdv = o_trc_rdv; obs.rd = o_trc_rd;
      obs.rdw = o_trc_rdw; obs.mem = o_trc_mem; obs.msiz = o_trc_msiz;
      obs.madr = o_trc_madr; obs.mdat = o_trc_mdat;
      checks++;
      assert (q.size() != 0) else begin
        failures++; $error("FAIL unexpected_record observed pc=%h expected none", o_trc_pc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (canon(obs) === canon(e.r)) else begin
          failures++; $error("FAIL record observed=%h expected=%h", canon(obs), canon(e.r));
        end
        if (e.x0) begin
          checks++;
          assert (d0_rdv === 1'b1) else begin
            failures++; $error("FAIL x0_nofilter_rdv observed=%b expected=1", d0_rdv);
          end
        end
      end
    end
  end

  task automatic m_commit();
    m_ret++;
    if (q.size() == DEPTH && !i_trc_rdy) begin
      if (m_drp != -1) m_drp++;
      m_ovf = 1'b1;
    end else begin
      q.push_back('{r: m_rec, x0: m_x0});
    end
  endtask

  task automatic cyc(input logic v, input logic [2:0] p, input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] w, input logic [31:0] rn, input logic f, input bit cm);
    @(posedge clk); #1;
    i_tcb_vld = v; i_tcb_rdy = 1'b1; i_pha = p; i_tcb_adr = a; i_tcb_siz = s;
    i_tcb_wdt = w; i_tcb_rdt = g_rdt; g_rdt = rn; i_flush = f; i_trc_rdy = g_rdy;
    if (cm) m_commit();
  endtask

  task automatic idle();
    cyc(1'b0, EXE, $urandom, 2'd0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic t_if(input logic [31:0] a, input logic [31:0] ins);
    cyc(1'b1, IF, a, 2'd2, $urandom, ins, 1'b0, m_open);
    m_rec = '0; m_rec.pc = a; m_rec.ins = ins; m_x0 = 1'b0; m_open = 1'b1;
  endtask

  task automatic t_wb(input logic [4:0] rd, input logic [31:0] w);
    cyc(1'b1, WB, {25'd0, rd, 2'b00}, 2'd2, w, $urandom, 1'b0, 1'b0);
    m_rec.rd = rd; m_rec.rdw = w; m_rec.rdv = (rd != 5'd0); m_x0 = (rd == 5'd0);
  endtask

  task automatic t_ld(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    cyc(1'b1, MLD, a, s, $urandom, d, 1'b0, 1'b0);
    m_rec.mem = 2'b01; m_rec.madr = a; m_rec.msiz = s; m_rec.mdat = d;
  endtask

  task automatic t_st(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
    cyc(1'b1, MST, a, s, w, $urandom, 1'b0, 1'b0);
    m_rec.mem = 2'b10; m_rec.madr = a; m_rec.msiz = s;
    case (s)
      2'd0:    m_rec.mdat = {24'd0, w[7:0]};
      2'd1:    m_rec.mdat = {16'd0, w[15:0]};
      default: m_rec.mdat = w;
    endcase
  endtask

  task automatic t_fl();
    cyc(1'b0, EXE, $urandom, 2'd0, $urandom, $urandom, 1'b1, m_open);
    m_open = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge clk);
    checks += 3;
    assert (o_cnt_ret === 32'(m_ret)) else begin
      failures++; $error("FAIL %s cnt_ret observed=%0d expected=%0d", tag, o_cnt_ret, m_ret); end
    assert (o_cnt_drp === 32'(m_drp)) else begin
      failures++; $error("FAIL %s cnt_drp observed=%0d expected=%0d", tag, o_cnt_drp, m_drp); end
    assert (o_ovf === m_ovf) else begin
      failures++; $error("FAIL %s ovf observed=%b expected=%b", tag, o_ovf, m_ovf); end
  endtask

  task automatic chk_zero(input string tag);
    logic [31:0] x;
    x = o_trc_pc | o_trc_ins | o_trc_rdw | o_trc_madr | o_trc_mdat | o_cnt_ret | o_cnt_drp |
        {22'd0, o_trc_vld, o_trc_rdv, o_trc_rd, o_trc_mem, o_trc_msiz} | {31'd0, o_ovf};
    checks++;
    assert (x === 32'd0) else begin
      failures++; $error("FAIL %s outputs observed_or=%h expected=0", tag, x); end
  endtask

  task automatic drain(input string tag);
    g_rdy = 1'b1;
    idle();
    for (int i = 0; i < 50 && q.size() != 0; i++) idle();
    idle();
    @(negedge clk);
    checks += 2;
    assert (q.size() == 0) else begin
      failures++; $error("FAIL %s drain_timeout observed=%0d pending expected=0", tag, q.size()); end
    assert (o_trc_vld === 1'b0) else begin
      failures++; $error("FAIL %s vld_after_drain observed=%b expected=0", tag, o_trc_vld); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    @(posedge clk); #1 rst = 1'b0;

    // Basic ALU instruction with an ignored RS1 transfer in between.
    t_if(32'h8000_0000, 32'h0050_0093); idle();
    cyc(1'b1, RS1, 32'h0000_005C, 2'd2, 32'hFFFF_FFFF, $urandom, 1'b0, 1'b0);
    t_wb(5'd1, 32'd5);
    t_if(32'h8000_0004, 32'h0000_2183); idle();
    chk_cnt("alu");
    // Word load, then a half load whose data is bypassed into the IF-cycle commit.
    t_ld(32'h0000_1000, 2'd2, 32'hDEAD_BEEF); idle(); t_wb(5'd3, 32'hDEAD_BEEF);
    t_if(32'h8000_0008, 32'h0040_1203); idle();
    t_ld(32'h0000_2004, 2'd1, 32'hCAFE_F00D);
    t_if(32'h8000_000C, 32'h0080_0023); idle();
    t_st(32'h0000_3000, 2'd0, 32'h1234_5678);
    t_if(32'h8000_0010, 32'h0080_1023); idle();
    t_st(32'h0000_3002, 2'd1, 32'h9ABC_DEF0); idle();
    t_fl();
    // Back-to-back IF, then a write-back to x0 closed by flush; a second flush commits nothing.
    t_if(32'h8000_0020, 32'h0000_0013);
    t_if(32'h8000_0024, 32'h0770_0013); idle();
    t_wb(5'd0, 32'h0000_0077); idle();
    t_fl(); idle(); t_fl(); idle();
    chk_cnt("flush");
    drain("basic");

    // Overflow: six commits with the sink stalled.
    g_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t_if(32'h8000_1000 + 32'(4 * i), 32'h0010_0013 + 32'(i << 7)); idle();
      t_wb(5'(i + 1), 32'(i * 32'h11));
    end
    t_fl(); idle();
    chk_cnt("overflow");
    checks++;
    assert (o_trc_vld === 1'b1 && o_trc_pc === 32'h8000_1000) else begin
      failures++; $error("FAIL overflow_head observed=%b/%h expected=1/80001000", o_trc_vld, o_trc_pc); end
    // Full with a pop in the commit cycle, then a stalled commit that must drop again.
    t_if(32'h8000_2000, 32'h0000_0513); idle(); t_wb(5'd10, 32'hA5A5_0001); idle();
    g_rdy = 1'b1; t_fl(); g_rdy = 1'b0;
    t_if(32'h8000_2004, 32'h0000_0593); idle(); t_wb(5'd11, 32'hA5A5_0002);
    t_fl(); idle();
    chk_cnt("full_push_pop");
    drain("overflow");

    // Reset in the middle of a record.
    t_if(32'h8000_3000, 32'h0010_0613); idle();
    @(posedge clk); #3 rst = 1'b1; #2;
    q.delete(); m_open = 1'b0; m_ret = 0; m_drp = 0; m_ovf = 1'b0;
    chk_zero("mid_record_reset");
    @(posedge clk); #1 rst = 1'b0;
    t_if(32'h8000_4000, 32'h0020_0693); idle(); t_wb(5'd13, 32'h0000_0002); idle();
    chk_cnt("after_reset");
    checks++;
    assert (o_trc_vld === 1'b0) else begin
      failures++; $error("FAIL after_reset_vld observed=%b expected=0", o_trc_vld); end
    t_fl(); idle();
    chk_cnt("flush_after_reset");
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/r5p_mouse_trace_capture.md
# r5p_mouse_trace_capture

Synthesizable, parametrised execution-trace capture unit for the R5P-mouse core. It snoops the core's TCB system bus and FSM phase and assembles one retire record per executed instruction: PC, instruction, GPR write-back, and load/store address and data. Records are buffered in a FIFO and presented on a valid/ready stream for an on-chip trace sink or a debug UART. It also keeps retire and drop counters.

## Interface
- `XLEN`, 32: data/address width (32 only for mouse; sets field widths).
- `DEPTH`, 4: record FIFO depth; power of 2, ≥2.
- `CNW`, 32: retire/drop counter width.
- `FILT_X0`, 1: when 1, a write-back to x0 sets `trc_rdv=0`.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `pha` in 3: core FSM phase (IF=000, MLD=001, MST=010, EXE=011, WB=100, RS1=101, RS2=110).
- `tcb_vld` in 1: TCB request valid.
- `tcb_rdy` in 1: TCB request ready; a transfer is `trn = tcb_vld & tcb_rdy`.
- `tcb_adr` in XLEN: request address.
- `tcb_siz` in 2: request size (0 byte, 1 half, 2 word).
- `tcb_wdt` in XLEN: write data.
- `tcb_rdt` in XLEN: read data, valid in the cycle after the transfer.
- `flush` in 1: commit the open record without a following IF.
- `trc_vld` out 1: record valid.
- `trc_rdy` in 1: record accepted.
- `trc_pc` out XLEN: PC.
- `trc_ins` out 32: instruction.
- `trc_rdv` out 1: GPR write present.
- `trc_rd` out 5: destination GPR.
- `trc_rdw` out XLEN: write-back data.
- `trc_mem` out 2: 00 none, 01 load, 10 store.
- `trc_msiz` out 2: memory access size.
- `trc_madr` out XLEN: memory address.
- `trc_mdat` out XLEN: load data, or store data masked to `trc_msiz`, zero-extended.
- `cnt_ret` out CNW: committed records; wraps.
- `cnt_drp` out CNW: dropped records; saturates at all-ones.
- `ovf` out 1: sticky, set on the first drop.

## Operation
- **Open record register.** Holds `open` plus all record fields. Only phases IF, WB, MLD and MST are recorded; RS1, RS2 and EXE transfers are ignored.
- **IF transfer, cycle t.**
  - If `open`, commit the record.
  - Start a new record: `pc=tcb_adr`, and clear rdv and mem.
  - Set a pending-instruction flag. In cycle t+1, `ins=tcb_rdt`.
- **WB transfer.**
  - `rd=tcb_adr[6:2]`, `rdw=tcb_wdt`.
  - `rdv=1`, except `rdv=0` when `FILT_X0=1` and rd==0.
- **MLD transfer.** `mem=01`, `madr=tcb_adr`, `msiz=tcb_siz`. Set a pending-load flag; in the next cycle `mdat=tcb_rdt`.
- **MST transfer.** `mem=10`, `madr=tcb_adr`, `msiz=tcb_siz`. `mdat` is `tcb_wdt` masked to 8, 16 or 32 bits.
- **Commit.**
  - Triggered by an IF transfer or by `flush`, but only when `open`.
  - `flush` clears `open`.
  - `flush` coinciding with an IF transfer counts as a single commit.
  - If a load response is due in the commit cycle, the committed `mdat` bypasses directly from `tcb_rdt`.
- **First IF after reset.** Nothing is open, so nothing is committed.
- **FIFO.**
  - Push on commit when not full, or when full and popping in the same cycle (pop frees the slot).
  - Pop on `trc_vld & trc_rdy`.
  - Read/write pointers are `log2(DEPTH)+1` bits and wrap.
- **Drop.**
  - Occurs on a commit while full with no pop.
  - The record is lost: `cnt_drp` increments (saturating) and `ovf` is set.
  - `cnt_ret` counts every commit, including dropped ones.
- **Reset** (async, any time, including mid-record):
  - `open`, pending flags, FIFO pointers, counters and `ovf` are cleared to 0.
  - Outputs read 0: `trc_vld=0`, and all `trc_*` data are 0.

## Timing
- Commit at cycle t is written to the FIFO at the edge ending t. `trc_vld` rises in cycle t+1 if the FIFO was empty; there is no same-cycle fall-through.
- `cnt_ret`, `cnt_drp` and `ovf` update at the same edge as the commit.
- `trc_*` data are registered FIFO-head outputs and are held stable while `trc_vld & ~trc_rdy`.
- Sustained throughput is 1 record per cycle. The minimum mouse instruction length (≥3 cycles) never saturates it when `trc_rdy=1`.
- Back-to-back IF transfers (t, t+1): the record opened at t commits at t+1 with its `ins` bypassed from `tcb_rdt`.

## Test plan
- **Basic ALU instruction.**
  - Stimulus: IF adr=0x80000000, rdt=0x00500093; then WB adr=0x4, wdt=5; then IF adr=0x80000004.
  - Response: one record with pc=0x80000000, ins=0x00500093, rdv=1, rd=1, rdw=5, mem=00; `cnt_ret=1`.
- **Load and store.**
  - Load: MLD adr=0x1000, siz=2, rdt=0xDEADBEEF. Record has mem=01, madr=0x1000, mdat=0xDEADBEEF.
  - Store: MST siz=0, wdt=0x12345678. Record has mem=10, mdat=0x00000078.
- **x0 filtering.** WB with rd=0 gives rdv=0 when `FILT_X0=1`, and rdv=1 when `FILT_X0=0`.
- **Overflow.**
  - Stimulus: `DEPTH=4`, `trc_rdy=0`, 6 commits.
  - Response: 4 records stored, `cnt_drp=2`, `ovf=1`, `cnt_ret=6`. Releasing `trc_rdy` yields the first 4 records in order.
- **Full with simultaneous push and pop.** Both in the same cycle: no drop, and occupancy stays 4.
- **Reset and flush.**
  - Assert `rst` mid-record (after IF, before WB): all outputs 0, and the next IF commits nothing.
  - `flush` after a WB commits exactly one record.
